hololink_init_seq: RTL

Post-reset register initialization sequencer for the Hololink host-interface register space. After reset release and a programmable settle delay, it walks the `N_INIT_REG` entry table of `{32b addr, 32b data}` pairs and issues one APB write per entry, in index order. It reports completion and errors, and supports a software-triggered rerun. It sits between the board-level init table and the internal APB register bus that feeds the instruction decoders (e.g. `stx_udp_port` setup).

---
 rtl/hololink_init_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/hololink_init_seq.sv
// hololink_init_seq: post-reset APB init sequencer. After a settle delay it
// writes every {addr, data} entry of the init table in index order, records
// the first failing entry, and can be rerun from software once finished.
module hololink_init_seq #(
  parameter int unsigned N_INIT_REG  = 2,
  parameter logic [63:0] INIT_REG [(N_INIT_REG > 0) ? N_INIT_REG : 1] =
    '{64'h0200_0024_0000_12B7, 64'h0201_0024_0000_12B7},
  parameter int unsigned START_DELAY = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        i_apb_clk,
  input  logic        i_apb_rst_n,
  input  logic        i_rerun,
  output logic        o_apb_psel,
  output logic        o_apb_penable,
  output logic        o_apb_pwrite,
  output logic [31:0] o_apb_paddr,
  output logic [31:0] o_apb_pwdata,
  input  logic        i_apb_pready,
  input  logic        i_apb_pslverr,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_init_err,
  output logic [7:0]  o_err_idx
);

  localparam int unsigned TBL_N      = (N_INIT_REG > 0) ? N_INIT_REG : 1;
  localparam logic [15:0] DLY_LAST   = 16'(START_DELAY - 1);
  localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT);
  localparam logic [7:0]  IDX_LAST   = 8'((N_INIT_REG > 0) ? N_INIT_REG - 1 : 0);
  localparam bit          NO_ENTRIES = (N_INIT_REG == 0);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_dly_cnt;
  logic [15:0] w_dly_next;
  logic [15:0] r_to_cnt;
  logic [15:0] w_to_next;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_next;
  logic [31:0] r_paddr;
  logic [31:0] w_paddr_next;
  logic [31:0] r_pwdata;
  logic [31:0] w_pwdata_next;
  logic        r_err;
  logic        w_err_next;
  logic [7:0]  r_err_idx;
  logic [7:0]  w_err_idx_next;

  // Table widened to the full 8-bit index range; unused slots read as zero
  // so the lookup index never needs truncating.
  logic [63:0] w_tbl [256];
  logic [7:0]  w_load_idx;
  logic [63:0] w_tbl_entry;
  logic        w_xfer_end;
  logic        w_xfer_fail;

  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_tbl
      if (gi < TBL_N) begin : g_used
        assign w_tbl[gi] = INIT_REG[gi];
      end else begin : g_pad
        assign w_tbl[gi] = 64'd0;
      end
    end
  endgenerate

  // The entry about to be presented in SETUP: 0 when leaving WAIT, else idx+1.
  assign w_load_idx  = (r_state == S_ACCESS) ? (r_idx + 8'd1) : 8'd0;
  assign w_tbl_entry = w_tbl[w_load_idx];

  // A transfer ends on pready or when the wait budget is exhausted; a
  // timeout is treated exactly like a slave error.
  assign w_xfer_end  = i_apb_pready || (r_to_cnt == TO_LIMIT);
  assign w_xfer_fail = i_apb_pready ? i_apb_pslverr : 1'b1;

  // Next-state and next-register logic for the sequencer.
  always_comb begin
    w_state_next   = r_state;
    w_dly_next     = r_dly_cnt;
    w_to_next      = r_to_cnt;
    w_idx_next     = r_idx;
    w_paddr_next   = r_paddr;
    w_pwdata_next  = r_pwdata;
    w_err_next     = r_err;
    w_err_idx_next = r_err_idx;
    case (r_state)
      S_WAIT: begin
        w_idx_next = 8'd0;
        if (r_dly_cnt == DLY_LAST) begin
          if (NO_ENTRIES) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next  = S_SETUP;
            w_paddr_next  = w_tbl_entry[63:32];
            w_pwdata_next = w_tbl_entry[31:0];
            w_to_next     = 16'd0;
          end
        end else begin
          w_dly_next = r_dly_cnt + 16'd1;
        end
      end
      S_SETUP: begin
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!w_xfer_end) begin
          w_to_next = r_to_cnt + 16'd1;
        end else begin
          if (w_xfer_fail && !r_err) begin
            w_err_next     = 1'b1;
            w_err_idx_next = r_idx;
          end
          if (r_idx == IDX_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next  = S_SETUP;
            w_idx_next    = r_idx + 8'd1;
            w_paddr_next  = w_tbl_entry[63:32];
            w_pwdata_next = w_tbl_entry[31:0];
            w_to_next     = 16'd0;
          end
        end
      end
      S_DONE: begin
        if (i_rerun) begin
          w_state_next   = S_WAIT;
          w_err_next     = 1'b0;
          w_err_idx_next = 8'd0;
          w_idx_next     = 8'd0;
          w_dly_next     = 16'd0;
        end
      end
      default: begin
        w_state_next = S_WAIT;
      end
    endcase
  end

  // State and datapath registers; reset aborts any bus cycle immediately.
  always_ff @(posedge i_apb_clk or negedge i_apb_rst_n) begin
    if (!i_apb_rst_n) begin
      r_state   <= S_WAIT;
      r_dly_cnt <= 16'd0;
      r_to_cnt  <= 16'd0;
      r_idx     <= 8'd0;
      r_paddr   <= 32'd0;
      r_pwdata  <= 32'd0;
      r_err     <= 1'b0;
      r_err_idx <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_dly_cnt <= w_dly_next;
      r_to_cnt  <= w_to_next;
      r_idx     <= w_idx_next;
      r_paddr   <= w_paddr_next;
      r_pwdata  <= w_pwdata_next;
      r_err     <= w_err_next;
      r_err_idx <= w_err_idx_next;
    end
  end

  // Outputs decode only registered state, so no input reaches an output
  // combinationally.
  assign o_apb_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign o_apb_penable = (r_state == S_ACCESS);
  assign o_apb_pwrite  = o_apb_psel;
  assign o_apb_paddr   = r_paddr;
  assign o_apb_pwdata  = r_pwdata;
  assign o_busy        = (r_state != S_DONE);
  assign o_init_done   = (r_state == S_DONE);
  assign o_init_err    = r_err;
  assign o_err_idx     = r_err_idx;

endmodule
